cadr_ddram_bridge: RTL and testbench
====================================

Name: cadr_ddram_bridge

Overview:
- Downstream of the CADR core's main-memory port; drives the MiSTer DDRAM_* interface on the emu top level.
- Converts single 32-bit word read/write requests into single-beat 64-bit DDR3 transactions with byte enables.
- Holds a one-line (64-bit) read buffer, so the second word of a doubleword is served without a DDR3 round trip.
- Holds off after reset so stale read beats from the DDR3 controller are discarded.

Parameters:
- BASE_ADDR, 29'h0600_0000: DDR3 base address in 64-bit units (byte 0x3000_0000).
- ADDR_W, 22: CPU word-address width.
- HOLDOFF, 256: cycles after reset during which requests are refused and DOUT_READY is discarded.
- LINE_EN, 1: 1 enables the read line buffer; 0 makes every read go to DDR3.

Ports:
- clk  in  1  system clock; also driven out on DDRAM_CLK.
- reset_n  in  1  synchronous, active-low reset.
- inv  in  1  one-cycle pulse that invalidates the line buffer.
- req  in  1  request strobe, held high until ack.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  word address; sampled with req.
- wdata  in  32  write data.
- rdata  out  32  read data; valid in the ack cycle, held until the next read ack.
- ack  out  1  one-cycle completion pulse.
- DDRAM_CLK  out  1  equals clk.
- DDRAM_BUSY  in  1  controller stall.
- DDRAM_BURSTCNT  out  8  constant 1.
- DDRAM_ADDR  out  29  BASE_ADDR + addr[ADDR_W-1:1].
- DDRAM_DOUT  in  64  read beat.
- DDRAM_DOUT_READY  in  1  read beat valid.
- DDRAM_RD  out  1  read command.
- DDRAM_DIN  out  64  {wdata,wdata}.
- DDRAM_BE  out  8  8'h0F if addr[0]=0, 8'hF0 if addr[0]=1.
- DDRAM_WE  out  1  write command.

Behaviour:
- Reset (reset_n=0 at a clk edge) forces:
  - outputs: ack=0, DDRAM_RD=0, DDRAM_WE=0, rdata=0;
  - internal: line valid=0, state HOLD, holdoff counter=HOLDOFF-1.
- Word placement: addr[0]=0 selects bits [31:0] of the 64-bit word; addr[0]=1 selects bits [63:32].
- HOLD: the counter decrements each cycle and DOUT_READY is ignored. At 0, go to IDLE. req is neither accepted nor acked in HOLD.
- IDLE, when req=1, the request is latched:
  - Read with line valid and tag == addr[ADDR_W-1:1] (hit): go to ACK; rdata = buffered half; ack rises on the next edge (latency 1).
  - Read miss: go to RD_ISSUE; DDRAM_RD=1 from the next cycle.
  - Write: go to WR_ISSUE; DDRAM_WE=1 from the next cycle.
- RD_ISSUE / WR_ISSUE: the command and DDRAM_ADDR/BE/DIN stay stable while DDRAM_BUSY=1. The command is accepted on the first edge with BUSY=0; the strobe then drops the next cycle.
  - Write accepted: go to ACK.
  - Read accepted: go to RD_WAIT.
- RD_WAIT: on DOUT_READY=1:
  - line buffer ← DOUT, tag ← latched addr[ADDR_W-1:1], valid ← LINE_EN;
  - rdata ← selected half of DOUT;
  - go to ACK.
- ACK: ack=1 for exactly one cycle, then IDLE.
  - req must be low or carry a new request in the IDLE cycle.
  - A req still high in IDLE is treated as a new request; the master is responsible for dropping req.
- Write-through: a write whose tag matches a valid line updates that half of the buffer in the same cycle it is latched. The write always goes to DDR3.
- inv: clears valid in any state. If inv and a hit decision occur in the same cycle, inv wins: the access is a miss and goes to DDR3.
- DOUT_READY outside RD_WAIT is ignored.
- Reset during RD_ISSUE/RD_WAIT/WR_ISSUE: the command is abandoned, and the HOLDOFF window absorbs any late beat.
- Only one transaction is outstanding at any time; BURSTCNT is always 1.

Test Plan:
- Reset for 1 cycle, then req at cycle 10 → no ack and no DDRAM_RD until cycle HOLDOFF (256) after reset; request accepted afterwards.
- Write addr=22'h000005, wdata=32'hDEADBEEF, BUSY high for 3 cycles → DDRAM_WE high 4 cycles, DDRAM_ADDR=29'h0600_0002, BE=8'hF0, DIN=64'hDEADBEEF_DEADBEEF, single ack after acceptance.
- Read addr=4 miss, DOUT=64'h11111111_22222222 after 7 cycles → rdata=32'h22222222 with ack. Then read addr=5 → ack 1 cycle after req with rdata=32'h11111111 and no DDRAM_RD.
- After filling line for addr=4/5, write addr=5 data 32'hCAFEF00D → next read addr=5 hits and returns 32'hCAFEF00D. Then inv pulse → read addr=4 issues DDRAM_RD.
- Reset asserted during RD_WAIT, DOUT_READY arriving 20 cycles later with 64'hBAD → ignored. After holdoff, read addr=8 returns the fresh beat, not 64'hBAD.
- LINE_EN=0: two consecutive reads of addr=4 and addr=5 → two DDRAM_RD transactions, both acked with the correct halves.

Source files
------------

// File: rtl/cadr_ddram_bridge.sv
// cadr_ddram_bridge
//   Bridges the CADR core's 32-bit main-memory port onto the MiSTer DDRAM_*
//   interface. Every CPU word access becomes one single-beat 64-bit DDR3
//   transaction with byte enables. A one-line (64-bit) read buffer serves the
//   other word of the most recently fetched doubleword without a DDR3 round trip.
//   After reset the bridge holds off for HOLDOFF cycles. During that time it
//   refuses requests and discards read beats that the controller may still
//   deliver for a command abandoned by the reset.
//
// Ports
//   clk, reset_n        system clock, synchronous active-low reset
//   inv                 one-cycle pulse, invalidates the line buffer
//   req/we/addr/wdata   CPU request. The master holds req until ack.
//   rdata/ack           read data (held until the next read ack) and a
//                       one-cycle completion pulse
//   DDRAM_*             MiSTer DDR3 controller port; DDRAM_CLK mirrors clk
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_HOLD     | post-reset holdoff; requests refused, read beats discarded
// S_IDLE     | waiting for req; decides hit / read miss / write
// S_RD_ISSUE | DDRAM_RD asserted, held while DDRAM_BUSY
// S_WR_ISSUE | DDRAM_WE asserted, held while DDRAM_BUSY
// S_RD_WAIT  | read accepted, waiting for DDRAM_DOUT_READY
// S_ACK      | ack high for exactly this cycle
module cadr_ddram_bridge #(
  parameter logic [28:0] BASE_ADDR = 29'h0600_0000,
  parameter int          ADDR_W    = 22,
  parameter int          HOLDOFF   = 256,
  parameter bit          LINE_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inv,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              DDRAM_CLK,
  input  logic              DDRAM_BUSY,
  output logic [7:0]        DDRAM_BURSTCNT,
  output logic [28:0]       DDRAM_ADDR,
  input  logic [63:0]       DDRAM_DOUT,
  input  logic              DDRAM_DOUT_READY,
  output logic              DDRAM_RD,
  output logic [63:0]       DDRAM_DIN,
  output logic [7:0]        DDRAM_BE,
  output logic              DDRAM_WE
);

  localparam int TAG_W = ADDR_W - 1;

  typedef enum logic [2:0] {
    S_HOLD,
    S_IDLE,
    S_RD_ISSUE,
    S_WR_ISSUE,
    S_RD_WAIT,
    S_ACK
  } state_t;

  state_t             state;
  logic [15:0]        hold_cnt;
  logic [63:0]        line;
  logic [TAG_W-1:0]   line_tag;
  logic               line_valid;
  logic [TAG_W-1:0]   lat_tag;
  logic               lat_hi;

  logic [TAG_W-1:0]   req_tag;
  logic               tag_match;
  logic [28:0]        req_ddr_addr;

  assign DDRAM_CLK      = clk;
  assign DDRAM_BURSTCNT = 8'd1;

  // The word address drops its lowest bit: two CPU words share one 64-bit
  // DDR3 location. A same-cycle inv kills the hit, so the access goes to DDR3.
  always_comb begin
    req_tag      = addr[ADDR_W-1:1];
    tag_match    = line_valid && (line_tag == req_tag) && !inv;
    req_ddr_addr = BASE_ADDR + {{(30-ADDR_W){1'b0}}, req_tag};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_HOLD;
      hold_cnt   <= 16'(HOLDOFF - 1);
      ack        <= 1'b0;
      rdata      <= 32'h0;
      DDRAM_RD   <= 1'b0;
      DDRAM_WE   <= 1'b0;
      DDRAM_ADDR <= 29'h0;
      DDRAM_DIN  <= 64'h0;
      DDRAM_BE   <= 8'h0;
      line       <= 64'h0;
      line_tag   <= '0;
      line_valid <= 1'b0;
      lat_tag    <= '0;
      lat_hi     <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          if (hold_cnt == 16'd0) state <= S_IDLE;
          else                   hold_cnt <= hold_cnt - 16'd1;
        end

        S_IDLE: begin
          if (req) begin
            lat_tag    <= req_tag;
            lat_hi     <= addr[0];
            DDRAM_ADDR <= req_ddr_addr;
            DDRAM_BE   <= addr[0] ? 8'hF0 : 8'h0F;
            DDRAM_DIN  <= {wdata, wdata};
            if (we) begin
              // Write-through keeps the buffered line coherent with DDR3.
              if (tag_match) begin
                if (addr[0]) line[63:32] <= wdata;
                else         line[31:0]  <= wdata;
              end
              DDRAM_WE <= 1'b1;
              state    <= S_WR_ISSUE;
            end else if (tag_match) begin
              rdata <= addr[0] ? line[63:32] : line[31:0];
              ack   <= 1'b1;
              state <= S_ACK;
            end else begin
              DDRAM_RD <= 1'b1;
              state    <= S_RD_ISSUE;
            end
          end
        end

        S_RD_ISSUE: begin
          if (!DDRAM_BUSY) begin
            DDRAM_RD <= 1'b0;
            state    <= S_RD_WAIT;
          end
        end

        S_WR_ISSUE: begin
          if (!DDRAM_BUSY) begin
            DDRAM_WE <= 1'b0;
            ack      <= 1'b1;
            state    <= S_ACK;
          end
        end

        S_RD_WAIT: begin
          if (DDRAM_DOUT_READY) begin
            line       <= DDRAM_DOUT;
            line_tag   <= lat_tag;
            line_valid <= LINE_EN;
            rdata      <= lat_hi ? DDRAM_DOUT[63:32] : DDRAM_DOUT[31:0];
            ack        <= 1'b1;
            state      <= S_ACK;
          end
        end

        S_ACK: begin
          ack   <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_HOLD;
      endcase

      // Takes priority over any fill in the same cycle.
      if (inv) line_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cadr_ddram_bridge.sv
module tb_cadr_ddram_bridge;

  localparam int HOLDOFF = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        inv = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [21:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy = 1'b0;
  logic [63:0] dout = '0;
  logic        dout_ready = 1'b0;
  logic        sel = 1'b0;

  logic        req_a, req_b;
  logic [31:0] a_rdata, b_rdata;
  logic        a_ack, b_ack, a_dclk, b_dclk, a_rd, b_rd, a_we, b_we;
  logic [7:0]  a_burst, b_burst, a_be, b_be;
  logic [28:0] a_addr, b_addr;
  logic [63:0] a_din, b_din;

  logic [31:0] m_rdata;
  logic        m_ack, m_rd, m_we;
  logic [7:0]  m_be;
  logic [28:0] m_addr;
  logic [63:0] m_din;

  always #5 clk = ~clk;

  assign req_a   = req & ~sel;
  assign req_b   = req & sel;
  assign m_rdata = sel ? b_rdata : a_rdata;
  assign m_ack   = sel ? b_ack   : a_ack;
  assign m_rd    = sel ? b_rd    : a_rd;
  assign m_we    = sel ? b_we    : a_we;
  assign m_be    = sel ? b_be    : a_be;
  assign m_addr  = sel ? b_addr  : a_addr;
  assign m_din   = sel ? b_din   : a_din;

  cadr_ddram_bridge #(.HOLDOFF(HOLDOFF), .LINE_EN(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .inv(inv), .req(req_a), .we(we), .addr(addr),
    .wdata(wdata), .rdata(a_rdata), .ack(a_ack), .DDRAM_CLK(a_dclk),
    .DDRAM_BUSY(busy), .DDRAM_BURSTCNT(a_burst), .DDRAM_ADDR(a_addr),
    .DDRAM_DOUT(dout), .DDRAM_DOUT_READY(dout_ready), .DDRAM_RD(a_rd),
    .DDRAM_DIN(a_din), .DDRAM_BE(a_be), .DDRAM_WE(a_we)
  );

  cadr_ddram_bridge #(.HOLDOFF(HOLDOFF), .LINE_EN(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .inv(inv), .req(req_b), .we(we), .addr(addr),
    .wdata(wdata), .rdata(b_rdata), .ack(b_ack), .DDRAM_CLK(b_dclk),
    .DDRAM_BUSY(busy), .DDRAM_BURSTCNT(b_burst), .DDRAM_ADDR(b_addr),
    .DDRAM_DOUT(dout), .DDRAM_DOUT_READY(dout_ready), .DDRAM_RD(b_rd),
    .DDRAM_DIN(b_din), .DDRAM_BE(b_be), .DDRAM_WE(b_we)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  inv_mode;   // 0 none, 1 pulse before req, 2 with req
    logic        wr;
    logic [21:0] a;
    logic [31:0] wd;
    logic [63:0] rsp;
    int          busy_n;
    int          rsp_lat;
    logic        exp_rd;
    logic        exp_we;
    logic [28:0] exp_addr;
    logic [7:0]  exp_be;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cur_row = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h required=%h", nm, cur_row, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, ack_cnt, cmd_cyc, lat, busy_left, wait_left;
    bit saw_rd, saw_we, done, pend;
    logic [28:0] c_addr;
    logic [7:0]  c_be;
    logic [63:0] c_din;
    logic [31:0] c_rdata;
    cur_row = idx;
    cyc = 0; ack_cnt = 0; cmd_cyc = 0; lat = 0; wait_left = 0;
    saw_rd = 0; saw_we = 0; done = 0; pend = 0;
    c_addr = '0; c_be = '0; c_din = '0; c_rdata = '0;
    sel = v.sel;
    if (v.inv_mode == 2'd1) begin
      inv = 1'b1;
      @(posedge clk); #1;
      inv = 1'b0;
    end
    req = 1'b1; we = v.wr; addr = v.a; wdata = v.wd;
    inv = (v.inv_mode == 2'd2);
    busy = (v.busy_n > 0);
    busy_left = v.busy_n;
    while (!done && cyc < 700) begin
      @(posedge clk); #1;
      cyc++;
      inv = 1'b0;
      dout_ready = 1'b0;
      if (m_rd || m_we) begin
        saw_rd = saw_rd | m_rd;
        saw_we = saw_we | m_we;
        cmd_cyc++;
        c_addr = m_addr; c_be = m_be; c_din = m_din;
        if (busy) begin
          if (busy_left == 0) busy = 1'b0;
          else busy_left--;
        end
        if (!busy && m_rd) begin
          pend = 1;
          wait_left = v.rsp_lat;
        end
      end else if (pend) begin
        if (wait_left <= 1) begin
          dout = v.rsp;
          dout_ready = 1'b1;
          pend = 0;
        end else wait_left--;
      end
      if (m_ack) begin
        ack_cnt++;
        c_rdata = m_rdata;
        lat = cyc;
        req = 1'b0;
      end else if (ack_cnt > 0) done = 1;
    end
    req = 1'b0; busy = 1'b0; dout_ready = 1'b0; inv = 1'b0;
    chk("completed", 64'(done), 64'd1);
    chk("ack_count", 64'(ack_cnt), 64'd1);
    chk("rd_issued", 64'(saw_rd), 64'(v.exp_rd));
    chk("we_issued", 64'(saw_we), 64'(v.exp_we));
    if (v.exp_rd || v.exp_we) begin
      chk("ddram_addr", 64'(c_addr), 64'(v.exp_addr));
      chk("ddram_be", 64'(c_be), 64'(v.exp_be));
      chk("cmd_cycles", 64'(cmd_cyc), 64'(v.busy_n + 1));
    end
    if (v.exp_we) chk("ddram_din", c_din, {v.wd, v.wd});
    if (!v.wr) chk("rdata", 64'(c_rdata), 64'(v.exp_rdata));
    if (v.exp_lat != 0) chk("hit_latency", 64'(lat), 64'(v.exp_lat));
  endtask

  vec_t vecs[14];
  vec_t post;

  initial begin
    int k, first_rd, early_ack, bad_ack;

    vecs[0]  = '{1'b0, 2'd0, 1'b1, 22'h000005, 32'hDEADBEEF, 64'h0,                   3, 0, 1'b0, 1'b1, 29'h0600_0002, 8'hF0, 32'h0,        0};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 22'h000004, 32'h0,        64'h11111111_22222222,   0, 7, 1'b1, 1'b0, 29'h0600_0002, 8'h0F, 32'h22222222, 0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 22'h000005, 32'h0,        64'h0,                   0, 0, 1'b0, 1'b0, 29'h0,         8'h0,  32'h11111111, 1};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 22'h000005, 32'hCAFEF00D, 64'h0,                   0, 0, 1'b0, 1'b1, 29'h0600_0002, 8'hF0, 32'h0,        0};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 22'h000005, 32'h0,        64'h0,                   0, 0, 1'b0, 1'b0, 29'h0,         8'h0,  32'hCAFEF00D, 1};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 22'h000004, 32'h0,        64'h0,                   0, 0, 1'b0, 1'b0, 29'h0,         8'h0,  32'h22222222, 1};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 22'h000004, 32'h0,        64'hAAAA5555_12345678,   0, 3, 1'b1, 1'b0, 29'h0600_0002, 8'h0F, 32'h12345678, 0};
    vecs[7]  = '{1'b0, 2'd0, 1'b0, 22'h3FFFFF, 32'h0,        64'hFEDCBA98_76543210,   0, 2, 1'b1, 1'b0, 29'h061F_FFFF, 8'hF0, 32'hFEDCBA98, 0};
    vecs[8]  = '{1'b0, 2'd0, 1'b1, 22'h3FFFFE, 32'h0BADC0DE, 64'h0,                   1, 0, 1'b0, 1'b1, 29'h061F_FFFF, 8'h0F, 32'h0,        0};
    vecs[9]  = '{1'b0, 2'd0, 1'b0, 22'h3FFFFE, 32'h0,        64'h0,                   0, 0, 1'b0, 1'b0, 29'h0,         8'h0,  32'h0BADC0DE, 1};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 22'h3FFFFF, 32'h0,        64'h13579BDF_2468ACE0,   2, 4, 1'b1, 1'b0, 29'h061F_FFFF, 8'hF0, 32'h13579BDF, 0};
    vecs[11] = '{1'b0, 2'd0, 1'b0, 22'h3FFFFE, 32'h0,        64'h0,                   0, 0, 1'b0, 1'b0, 29'h0,         8'h0,  32'h2468ACE0, 1};
    vecs[12] = '{1'b1, 2'd0, 1'b0, 22'h000004, 32'h0,        64'h55556666_77778888,   0, 3, 1'b1, 1'b0, 29'h0600_0002, 8'h0F, 32'h77778888, 0};
    vecs[13] = '{1'b1, 2'd0, 1'b0, 22'h000005, 32'h0,        64'h9999AAAA_BBBBCCCC,   0, 3, 1'b1, 1'b0, 29'h0600_0002, 8'hF0, 32'h9999AAAA, 0};
    post     = '{1'b0, 2'd0, 1'b0, 22'h000008, 32'h0,        64'h01234567_89ABCDEF,   0, 5, 1'b1, 1'b0, 29'h0600_0004, 8'h0F, 32'h89ABCDEF, 0};

    // Reset values and holdoff window.
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_ack", 64'(a_ack), 64'd0);
    chk("reset_rd", 64'(a_rd), 64'd0);
    chk("reset_we", 64'(a_we), 64'd0);
    chk("reset_rdata", 64'(a_rdata), 64'd0);
    chk("burstcnt", 64'(a_burst), 64'd1);
    chk("ddram_clk", 64'(a_dclk), 64'(clk));
    reset_n = 1'b1;
    k = 0; first_rd = 0; early_ack = 0;
    while (first_rd == 0 && k < 400) begin
      if (k == 10) begin req = 1'b1; we = 1'b0; addr = 22'h000002; end
      @(posedge clk); #1;
      k++;
      if (a_ack) early_ack++;
      if (a_rd) first_rd = k;
    end
    chk("holdoff_first_rd", 64'(first_rd), 64'(HOLDOFF + 1));
    chk("holdoff_no_ack", 64'(early_ack), 64'd0);
    dout = 64'h00000003_00000002;
    repeat (3) begin @(posedge clk); #1; end
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;
    chk("holdoff_read_ack", 64'(a_ack), 64'd1);
    chk("holdoff_read_rdata", 64'(a_rdata), 64'h00000002);
    req = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);
    sel = 1'b0;
    cur_row = -1;

    // Reset while a read is waiting for its beat; the late beat must be dropped.
    req = 1'b1; we = 1'b0; addr = 22'h000008;
    k = 0;
    while (!a_rd && k < 20) begin @(posedge clk); #1; k++; end
    chk("rw_rd_issued", 64'(a_rd), 64'd1);
    @(posedge clk); #1;
    chk("rw_rd_dropped", 64'(a_rd), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("rw_reset_ack", 64'(a_ack), 64'd0);
    chk("rw_reset_rd", 64'(a_rd), 64'd0);
    chk("rw_reset_rdata", 64'(a_rdata), 64'd0);
    bad_ack = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 19) begin dout = 64'hBAD; dout_ready = 1'b1; end
      else dout_ready = 1'b0;
      @(posedge clk); #1;
      if (a_ack) bad_ack++;
    end
    dout_ready = 1'b0;
    chk("late_beat_no_ack", 64'(bad_ack), 64'd0);
    chk("late_beat_rdata", 64'(a_rdata), 64'd0);
    run_vec(post, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
